// File: rtl/lsu_align.sv
// lsu_align: byte-addressed RV32I load/store front end for a 4096 x 32 word
// memory. Sub-word stores become read-modify-write sequences, accesses that
// straddle a word boundary become two-word accesses, and load data is
// extracted and extended here so the memory only ever sees full words.
module lsu_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        mem_we,
    output logic [2:0]  mem_ctrl,
    output logic [12:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, LD0, LD1, SRD0, SWR0, SRD1, SWR1, DONE} state_t;

    state_t      state;
    logic [2:0]  funct_q;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [1:0]  off;
    logic [31:0] wdata_q;
    logic [31:0] buf0;
    logic [31:0] buf1;

    logic [2:0]  size;
    logic [3:0]  mask_sz;
    logic        split;
    logic [31:0] st_dmask;
    logic [63:0] st_vec;
    logic [7:0]  st_bmask;
    logic [31:0] ld_lo;
    logic [31:0] ld_hi;
    logic [63:0] ld_cat;
    logic [31:0] ld_win;
    logic [31:0] ld_val;

    // Address bits above the 16 KiB window alias and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:14];

    // Byte-lane replace: take new byte where the mask is set, keep old otherwise.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? nw[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    // Access size and byte-enable pattern of the latched request.
    always_comb begin
        case (funct_q)
            3'd0, 3'd3, 3'd5: begin size = 3'd1; mask_sz = 4'b0001; end
            3'd1, 3'd4, 3'd6: begin size = 3'd2; mask_sz = 4'b0011; end
            default:          begin size = 3'd4; mask_sz = 4'b1111; end
        endcase
    end

    assign split    = ({1'b0, off} + size) > 3'd4;
    assign w1       = w0 + 12'd1;              // word 4095 wraps to word 0
    assign st_dmask = {{8{mask_sz[3]}}, {8{mask_sz[2]}}, {8{mask_sz[1]}}, {8{mask_sz[0]}}};
    assign st_vec   = {32'd0, wdata_q & st_dmask} << {off, 3'b000};
    assign st_bmask = {4'd0, mask_sz} << off;

    // Load assembly. In LD0 the word is still on mem_rdata (buf0 not yet
    // written); in LD1 the low word sits in buf0 and the high word on the bus.
    always_comb begin
        ld_lo  = (state == LD1) ? buf0 : mem_rdata;
        ld_hi  = (state == LD1) ? mem_rdata : 32'd0;
        ld_cat = {ld_hi, ld_lo};
        ld_win = ld_cat[{off, 3'b000} +: 32];
        case (funct_q)
            3'd0:    ld_val = {{24{ld_win[7]}},  ld_win[7:0]};
            3'd1:    ld_val = {{16{ld_win[15]}}, ld_win[15:0]};
            3'd3:    ld_val = {24'd0, ld_win[7:0]};
            3'd4:    ld_val = {16'd0, ld_win[15:0]};
            default: ld_val = ld_win;
        endcase
    end

    // Sequencer: request latch, read captures, response register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            funct_q    <= 3'd0;
            w0         <= 12'd0;
            off        <= 2'd0;
            wdata_q    <= 32'd0;
            buf0       <= 32'd0;
            buf1       <= 32'd0;
            resp_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    funct_q <= req_funct;
                    w0      <= req_addr[13:2];
                    off     <= req_addr[1:0];
                    wdata_q <= req_wdata;
                    if (req_funct < 3'd5)
                        state <= LD0;
                    else if (req_funct == 3'd7 && req_addr[1:0] == 2'd0)
                        state <= SWR0;     // full aligned word needs no read
                    else
                        state <= SRD0;
                end
                LD0: begin
                    buf0 <= mem_rdata;
                    if (split) state <= LD1;
                    else begin
                        resp_rdata <= ld_val;
                        state      <= DONE;
                    end
                end
                LD1: begin
                    buf1       <= mem_rdata;
                    resp_rdata <= ld_val;
                    state      <= DONE;
                end
                SRD0: begin
                    buf0  <= mem_rdata;
                    state <= SWR0;
                end
                SWR0: begin
                    if (split) state <= SRD1;
                    else begin
                        resp_rdata <= 32'd0;
                        state      <= DONE;
                    end
                end
                SRD1: begin
                    buf1  <= mem_rdata;
                    state <= SWR1;
                end
                SWR1: begin
                    resp_rdata <= 32'd0;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side and handshake outputs; all forced quiet while in reset so
    // a reset landing on a write cycle never reaches the array.
    always_comb begin
        req_ready  = rst_n && (state == IDLE);
        resp_valid = rst_n && (state == DONE);
        mem_we     = 1'b0;
        mem_ctrl   = 3'd2;
        mem_addr   = 13'd0;
        mem_wdata  = 32'd0;
        if (rst_n) begin
            case (state)
                LD0, SRD0: mem_addr = {1'b0, w0};
                LD1, SRD1: mem_addr = {1'b0, w1};
                SWR0: begin
                    // An aligned sw has mask 4'hF, so the unread buf0 is fully replaced.
                    mem_addr  = {1'b0, w0};
                    mem_we    = 1'b1;
                    mem_ctrl  = 3'd7;
                    mem_wdata = merge(buf0, st_vec[31:0], st_bmask[3:0]);
                end
                SWR1: begin
                    mem_addr  = {1'b0, w1};
                    mem_we    = 1'b1;
                    mem_ctrl  = 3'd7;
                    mem_wdata = merge(buf1, st_vec[63:32], st_bmask[7:4]);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: word memory environment plus a byte-array reference
// of the address space; directed cases followed by randomized requests.
module tb_lsu_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [2:0]  mem_ctrl;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_align dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, write on rising edge; preload port for the bench.
    logic [31:0] mem [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    end

    // Reference: the 16 KiB space as plain bytes, little-endian.
    logic [7:0]  rb [16384];
    int          passed = 0;
    int          total  = 0;
    logic [12:0] seen1, seen2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int fsize(input logic [2:0] f);
        if (f == 3'd0 || f == 3'd3 || f == 3'd5) return 1;
        if (f == 3'd1 || f == 3'd4 || f == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < fsize(f); i++) v[8*i +: 8] = rb[(int'(a[13:0]) + i) % 16384];
        if (f == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f == 3'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic set_word(input int w, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = w[11:0]; pre_data = d;
        for (int i = 0; i < 4; i++) rb[4*w+i] = d[8*i +: 8];
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // One request end to end: latency, data, write count, and touched words.
    task automatic do_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] got);
        int sz, off, w0, lat, wr, c7, lat_exp, wr_exp;
        logic sp, st;
        logic [31:0] exp_d;
        sz  = fsize(f);
        off = int'(a[1:0]);
        w0  = int'(a[13:2]);
        sp  = (off + sz) > 4;
        st  = (f >= 3'd5);
        exp_d   = st ? 32'd0 : ref_load(f, a);
        lat_exp = !st ? (sp ? 3 : 2) : (f == 3'd7 && off == 0) ? 2 : (sp ? 5 : 3);
        wr_exp  = st ? (sp ? 2 : 1) : 0;
        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1; req_funct = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_funct = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; wr = 0; c7 = 0; got = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) seen1 = mem_addr;
            if (c == 2) seen2 = mem_addr;
            if (mem_we) wr++;
            if (mem_ctrl == 3'd7) c7++;
            if (resp_valid) begin
                lat = c;
                got = resp_rdata;
                break;
            end
        end
        check("latency", lat, lat_exp);
        check("rdata", got, exp_d);
        check("write_pulses", wr, wr_exp);
        check("ctrl_write_cycles", c7, wr_exp);
        if (st) begin
            for (int i = 0; i < sz; i++) rb[(int'(a[13:0]) + i) % 16384] = wd[8*i +: 8];
            check("store_word0", mem[w0], ref_word(w0));
            if (sp) check("store_word1", mem[(w0 + 1) % 4096], ref_word((w0 + 1) % 4096));
        end
    endtask

    initial begin
        logic [31:0] got, a;
        int acc_n, resp_n, upd, w;
        int acc_t [2];
        int resp_t [2];
        logic [31:0] resp_d [2];

        rst_n = 1'b0; req_valid = 1'b0; req_funct = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        pre_we = 1'b0; pre_addr = 12'd0; pre_data = 32'd0;
        for (int i = 0; i < 4096; i++) set_word(i, $urandom);

        // Outputs held quiet in reset
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ctrl", mem_ctrl, 3'd2);
        check("rst_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_resp", resp_valid, 0);

        // lb / lbu of byte 2 of word 5
        set_word(5, 32'h8899AABB);
        do_req(3'd0, 32'h16, 32'h0, got);
        check("tp_lb", got, 32'hFFFFFF99);
        do_req(3'd3, 32'h16, 32'h0, got);
        check("tp_lbu", got, 32'h00000099);

        // sh inside one word
        set_word(5, 32'h11223344);
        do_req(3'd6, 32'h15, 32'h1234BEEF, got);
        check("tp_sh_word", mem[5], 32'h11BEEF44);

        // split lw and split sw across words 7/8
        set_word(7, 32'hDDCCBBAA);
        set_word(8, 32'h44332211);
        do_req(3'd2, 32'h1E, 32'h0, got);
        check("tp_lw_split", got, 32'h2211DDCC);
        do_req(3'd7, 32'h1F, 32'hCAFEF00D, got);
        check("tp_sw_w7", mem[7], 32'h0DCCBBAA);
        check("tp_sw_w8", mem[8], 32'h44CAFEF0);

        // lh wrapping from word 4095 to word 0
        set_word(4095, 32'h7F000000);
        set_word(0, 32'h000000C3);
        do_req(3'd1, 32'h3FFF, 32'h0, got);
        check("wrap_lh", got, 32'hFFFFC37F);
        check("wrap_addr_first", seen1, 13'd4095);
        check("wrap_addr_second", seen2, 13'd0);

        // Reset landing on the write cycle of an sb
        @(negedge clk);
        req_valid = 1'b1; req_funct = 3'd5; req_addr = 32'h25; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we_gated", mem_we, 0);
        @(negedge clk);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_resp", resp_valid, 0);
        check("mid_rst_rdata_clr", resp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_after", req_ready, 1);
        check("mid_rst_no_resp", resp_valid, 0);
        check("mid_rst_word_kept", mem[9], ref_word(9));

        // Back-to-back aligned lw with req_valid held high
        set_word(10, 32'h01020304);
        set_word(11, 32'hA0B0C0D0);
        @(negedge clk);
        req_valid = 1'b1; req_funct = 3'd2; req_addr = 32'h28;
        acc_n = 0; resp_n = 0; upd = 0;
        for (int c = 0; c < 20 && (acc_n < 2 || resp_n < 2); c++) begin
            if (upd == 1) req_addr = 32'h2C;
            if (upd == 2) req_valid = 1'b0;
            upd = 0;
            if (req_valid && req_ready && acc_n < 2) begin
                acc_t[acc_n] = c;
                acc_n++;
                upd = acc_n;
            end
            if (resp_valid && resp_n < 2) begin
                resp_t[resp_n] = c;
                resp_d[resp_n] = resp_rdata;
                resp_n++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b_accepts", acc_n, 2);
        check("b2b_resps", resp_n, 2);
        check("b2b_accept_gap", acc_t[1] - acc_t[0], 3);
        check("b2b_first_lat", resp_t[0] - acc_t[0], 2);
        check("b2b_resp_gap", resp_t[1] - resp_t[0], 3);
        check("b2b_data0", resp_d[0], 32'h01020304);
        check("b2b_data1", resp_d[1], 32'hA0B0C0D0);

        // Randomized mix around both ends of the array, with aliased upper bits
        for (int n = 0; n < 80; n++) begin
            w = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : 4088 + $urandom_range(0, 7);
            a = $urandom;
            a[13:2] = w[11:0];
            a[1:0]  = 2'($urandom_range(0, 3));
            do_req(3'($urandom_range(0, 7)), a, $urandom, got);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
